// File: rtl/ram64_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between requesters A and B.
// After reset it can sweep every word to CLEAR_VALUE before granting any access.
module ram64_arbiter #(
  parameter int                ADDR_W         = 6,
  parameter int                DATA_W         = 16,
  parameter int                CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              ram_load,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_in,
  input  logic [DATA_W-1:0] ram_out
);

  typedef enum logic {S_CLEAR, S_SERVE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                ptr_b_q, ptr_b_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                a_rvalid_q, a_rvalid_d;
  logic                b_rvalid_q, b_rvalid_d;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_SERVE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (state_q == S_CLEAR && cnt_q == {ADDR_W{1'b1}}) begin
      state_d = S_SERVE;
    end
  end

  // Output / arbitration logic; grants and RAM writes are suppressed during reset
  always_comb begin
    a_gnt       = 1'b0;
    b_gnt       = 1'b0;
    ram_load    = 1'b0;
    ram_address = '0;
    ram_in      = '0;
    busy        = (state_q == S_CLEAR);
    if (state_q == S_CLEAR) begin
      ram_load    = ~reset;
      ram_address = cnt_q;
      ram_in      = CLEAR_VALUE;
    end else if (!reset) begin
      a_gnt = a_req & (~b_req | ~ptr_b_q);
      b_gnt = b_req & (~a_req |  ptr_b_q);
      if (a_gnt) begin
        ram_load    = a_we;
        ram_address = a_addr;
        ram_in      = a_wdata;
      end else if (b_gnt) begin
        ram_load    = b_we;
        ram_address = b_addr;
        ram_in      = b_wdata;
      end
    end
  end

  always_comb begin
    cnt_d      = (state_q == S_CLEAR) ? cnt_q + 1'b1 : cnt_q;
    ptr_b_d    = a_gnt ? 1'b1 : (b_gnt ? 1'b0 : ptr_b_q);
    a_rvalid_d = a_gnt & ~a_we;
    b_rvalid_d = b_gnt & ~b_we;
    rdata_d    = (a_rvalid_d | b_rvalid_d) ? ram_out : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      ptr_b_q    <= 1'b0;
      rdata_q    <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      ptr_b_q    <= ptr_b_d;
      rdata_q    <= rdata_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
    end
  end

  assign rdata    = rdata_q;
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;

endmodule

// File: tb/tb_ram64_arbiter.sv
// Directed bench for ram64_arbiter with a behavioural RAM64 attached.
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_ram64_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, a_we, b_req, b_we;
  logic [5:0]  a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid, busy, ram_load;
  logic [15:0] rdata, ram_in, ram_out;
  logic [5:0]  ram_address;
  logic        fill;
  logic [15:0] mem [64];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram64_arbiter dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid),
    .rdata(rdata), .busy(busy),
    .ram_load(ram_load), .ram_address(ram_address), .ram_in(ram_in),
    .ram_out(ram_out)
  );

  // RAM starts with non-zero junk so the clear sweep is observable
  assign ram_out = mem[ram_address];
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 64; i++) mem[i] <= 16'hDEAD ^ 16'(i);
    end else if (ram_load) begin
      mem[ram_address] <= ram_in;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; fill = 1'b1;
    a_req = 1'b1; a_we = 1'b1; a_addr = 6'd0; a_wdata = 16'hFFFF;
    b_req = 1'b0; b_we = 1'b0; b_addr = 6'd0; b_wdata = 16'h0;

    // Reset state, requests present but must be ignored
    step(); fill = 1'b0; #1;
    chk("rst_a_gnt", a_gnt, 0);
    chk("rst_a_rvalid", a_rvalid, 0);
    chk("rst_b_rvalid", b_rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_ram_load", ram_load, 0);
    chk("rst_busy", busy, 1);

    // Clear sweep: 64 busy cycles, addresses 0..63, no grants
    step(); reset = 1'b0;
    for (int i = 0; i < 64; i++) begin
      #1;
      chk("clr_busy", busy, 1);
      chk("clr_load", ram_load, 1);
      chk("clr_addr", ram_address, i);
      chk("clr_in", ram_in, 0);
      chk("clr_a_gnt", a_gnt, 0);
      step();
    end
    #1; chk("clr_done_busy", busy, 0);

    // Read back every word, A alone back-to-back
    a_we = 1'b0;
    for (int i = 0; i < 64; i++) begin
      a_addr = 6'(i); #1;
      chk("rb_a_gnt", a_gnt, 1);
      chk("rb_a_rvalid", a_rvalid, (i > 0));
      chk("rb_rdata", rdata, 0);
      step();
    end
    a_req = 1'b0; #1;
    chk("rb_last_rvalid", a_rvalid, 1);
    chk("rb_last_rdata", rdata, 0);

    // A writes BEEF to 5 then reads it
    step(); a_req = 1'b1; a_we = 1'b1; a_addr = 6'd5; a_wdata = 16'hBEEF; #1;
    chk("t2_wr_gnt", a_gnt, 1);
    chk("t2_wr_load", ram_load, 1);
    chk("t2_wr_addr", ram_address, 5);
    chk("t2_wr_in", ram_in, 16'hBEEF);
    step(); a_we = 1'b0; #1;
    chk("t2_rd_gnt", a_gnt, 1);
    chk("t2_rd_load", ram_load, 0);
    chk("t2_rd_rvalid_early", a_rvalid, 0);
    step(); a_req = 1'b0; #1;
    chk("t2_rvalid", a_rvalid, 1);
    chk("t2_b_rvalid", b_rvalid, 0);
    chk("t2_rdata", rdata, 16'hBEEF);
    chk("t2_idle_load", ram_load, 0);
    chk("t2_idle_addr", ram_address, 0);

    // B alone writes 5555 to 20 (pointer returns to A)
    step(); b_req = 1'b1; b_we = 1'b1; b_addr = 6'd20; b_wdata = 16'h5555; #1;
    chk("b_wr_gnt", b_gnt, 1);
    chk("b_wr_a_gnt", a_gnt, 0);

    // Both read continuously: A,B,A,B
    step(); b_we = 1'b0; a_req = 1'b1; a_we = 1'b0; a_addr = 6'd5; #1;
    chk("t3_a_gnt0", a_gnt, 1); chk("t3_b_gnt0", b_gnt, 0);
    chk("t3_rv0", {a_rvalid, b_rvalid}, 2'b00);
    step(); #1;
    chk("t3_a_gnt1", a_gnt, 0); chk("t3_b_gnt1", b_gnt, 1);
    chk("t3_rv1", {a_rvalid, b_rvalid}, 2'b10); chk("t3_rd1", rdata, 16'hBEEF);
    step(); #1;
    chk("t3_a_gnt2", a_gnt, 1); chk("t3_b_gnt2", b_gnt, 0);
    chk("t3_rv2", {a_rvalid, b_rvalid}, 2'b01); chk("t3_rd2", rdata, 16'h5555);
    step(); #1;
    chk("t3_a_gnt3", a_gnt, 0); chk("t3_b_gnt3", b_gnt, 1);
    chk("t3_rv3", {a_rvalid, b_rvalid}, 2'b10); chk("t3_rd3", rdata, 16'hBEEF);
    step(); a_req = 1'b0; b_req = 1'b0; #1;
    chk("t3_rv4", {a_rvalid, b_rvalid}, 2'b01); chk("t3_rd4", rdata, 16'h5555);

    // B alone: write 1..4, then four back-to-back reads
    b_req = 1'b1; b_we = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      b_addr = 6'(i); b_wdata = 16'h1000 + 16'(i); #1;
      chk("t4_wr_gnt", b_gnt, 1);
      step();
    end
    b_we = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      b_addr = 6'(i); #1;
      chk("t4_rd_gnt", b_gnt, 1);
      chk("t4_rd_rvalid", b_rvalid, (i > 1));
      if (i > 1) chk("t4_rd_data", rdata, 16'h1000 + 16'(i - 1));
      step();
    end
    b_req = 1'b0; #1;
    chk("t4_last_rvalid", b_rvalid, 1);
    chk("t4_last_a_rvalid", a_rvalid, 0);
    chk("t4_last_data", rdata, 16'h1004);

    // Same-cycle A write 1234 to 9 and B read of 9, pointer at A
    step();
    a_req = 1'b1; a_we = 1'b1; a_addr = 6'd9; a_wdata = 16'h1234;
    b_req = 1'b1; b_we = 1'b0; b_addr = 6'd9; #1;
    chk("t5_a_gnt", a_gnt, 1); chk("t5_b_gnt", b_gnt, 0);
    chk("t5_load", ram_load, 1);
    step(); a_req = 1'b0; #1;
    chk("t5_b_gnt2", b_gnt, 1); chk("t5_a_gnt2", a_gnt, 0);
    chk("t5_rv_after_wr", {a_rvalid, b_rvalid}, 2'b00);
    chk("t5_rdata_hold", rdata, 16'h1004);
    step(); b_req = 1'b0; #1;
    chk("t5_b_rvalid", b_rvalid, 1);
    chk("t5_rdata", rdata, 16'h1234);

    // Pending rvalid dropped by reset; sweep restarts after a mid-sweep reset
    step(); a_req = 1'b1; a_we = 1'b0; a_addr = 6'd5; #1;
    chk("t6_a_gnt", a_gnt, 1);
    step(); a_req = 1'b0; reset = 1'b1; #1;
    chk("t6_rvalid_pre", a_rvalid, 1);
    chk("t6_rdata_pre", rdata, 16'hBEEF);
    chk("t6_load_rst", ram_load, 0);
    step(); reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      #1;
      chk("t6_sw1_addr", ram_address, i);
      chk("t6_sw1_rvalid", a_rvalid, 0);
      step();
    end
    #1;
    chk("t6_addr30", ram_address, 30);
    chk("t6_busy30", busy, 1);
    reset = 1'b1; #1;
    chk("t6_load_forced", ram_load, 0);
    step(); reset = 1'b0;
    for (int i = 0; i < 64; i++) begin
      #1;
      chk("t6_sw2_busy", busy, 1);
      chk("t6_sw2_addr", ram_address, i);
      step();
    end
    #1; chk("t6_done_busy", busy, 0);

    // Word 5 was cleared again by the restarted sweep
    a_req = 1'b1; a_addr = 6'd5; #1;
    chk("t6_rd_gnt", a_gnt, 1);
    step(); a_req = 1'b0; #1;
    chk("t6_rd_rvalid", a_rvalid, 1);
    chk("t6_rd_data", rdata, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
